cmp_result_tracker: RTL

//  - Downstream stage of the 2-bit magnitude comparator.
//  - Consumes its one-hot Lesser/Equal/Greater flags whenever in_valid is high.
//  - Keeps per-result saturating counts, an equal-streak counter and a lock flag, and tracks the last result.
//  - Flags illegal (non-one-hot) flag combinations.
//  - Gives control/debug logic a registered, stable summary of the compare stream.

---
 rtl/cmp_pkg.sv | 41 ++++
 rtl/cmp_result_tracker_if.sv | 10 +
 rtl/cmp_result_tracker_sat_counter.sv | 21 ++
 rtl/cmp_result_tracker.sv | 122 ++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - result/state types and flag decode for the compare result tracker
package cmp_pkg;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_LT   = 2'b01,
    RES_EQ   = 2'b10,
    RES_GT   = 2'b11
  } res_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LT   = 3'd1,
    EQ   = 3'd2,
    GT   = 3'd3,
    LOCK = 3'd4,
    ERR  = 3'd5
  } state_t;

  typedef struct packed {
    logic legal;
    res_t code;
  } dec_t;

  // One-hot flags map to a result code; anything else is illegal.
  function automatic dec_t decode(input logic lesser, input logic equal, input logic greater);
    dec_t d;
    d.legal = 1'b1;
    case ({lesser, equal, greater})
      3'b100:  d.code = RES_LT;
      3'b010:  d.code = RES_EQ;
      3'b001:  d.code = RES_GT;
      default: begin
        d.legal = 1'b0;
        d.code  = RES_NONE;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cmp_result_tracker_if.sv
// rtl/cmp_result_tracker_if.sv - comparator flag bus feeding the result tracker
interface cmp_result_tracker_if;
  logic in_valid;
  logic lesser;
  logic equal;
  logic greater;

  modport master (output in_valid, output lesser, output equal, output greater);
  modport slave  (input  in_valid, input  lesser, input  equal, input  greater);
endinterface

// File: rtl/cmp_result_tracker_sat_counter.sv
// rtl/cmp_result_tracker_sat_counter.sv - saturating up-counter with sync reset and clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on inc, stick at all-ones; rst and clr both return to zero first.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cmp_result_tracker.sv
// rtl/cmp_result_tracker.sv - registered summary of the comparator result stream; CMP_HIST_EN enables hist
module cmp_result_tracker
  import cmp_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int LOCK_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  cmp_result_tracker_if.slave  cmp,
  output logic [1:0]           last_res,
  output logic [CNT_W-1:0]     cnt_lt,
  output logic [CNT_W-1:0]     cnt_eq,
  output logic [CNT_W-1:0]     cnt_gt,
  output logic [CNT_W-1:0]     streak,
  output logic                 lock,
  output logic                 chg,
  output logic                 err,
  output logic [7:0]           hist
);

  state_t state_q;
  state_t state_d;
  dec_t   dec;
  logic   accept;
  logic   take;
  logic   take_lt;
  logic   take_eq;
  logic   take_gt;
  logic   eq_hit;
  logic [CNT_W:0] streak_inc;

  assign dec     = decode(cmp.lesser, cmp.equal, cmp.greater);
  // ERR swallows every further sample until clear/rst.
  assign accept  = cmp.in_valid && (state_q != ERR);
  assign take    = accept && dec.legal;
  assign take_lt = take && (dec.code == RES_LT);
  assign take_eq = take && (dec.code == RES_EQ);
  assign take_gt = take && (dec.code == RES_GT);

  // A saturated streak is always past LOCK_LEN, so the unsaturated sum is enough here.
  assign streak_inc = {1'b0, streak} + 1'b1;
  assign eq_hit     = streak_inc >= (CNT_W+1)'(LOCK_LEN);

  sat_counter #(.W(CNT_W)) u_cnt_lt (.clk(clk), .rst(rst), .clr(clear), .inc(take_lt), .q(cnt_lt));
  sat_counter #(.W(CNT_W)) u_cnt_eq (.clk(clk), .rst(rst), .clr(clear), .inc(take_eq), .q(cnt_eq));
  sat_counter #(.W(CNT_W)) u_cnt_gt (.clk(clk), .rst(rst), .clr(clear), .inc(take_gt), .q(cnt_gt));
  sat_counter #(.W(CNT_W)) u_streak (.clk(clk), .rst(rst), .clr(clear || take_lt || take_gt),
                                     .inc(take_eq), .q(streak));

  // State register; clear behaves exactly like rst.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows each accepted sample; illegal flags trap into ERR.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (!dec.legal) begin
        state_d = ERR;
      end else begin
        case (dec.code)
          RES_LT:  state_d = LT;
          RES_GT:  state_d = GT;
          RES_EQ:  state_d = eq_hit ? LOCK : EQ;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // err is a pure decode of the registered state, so it stays sticky with ERR.
  always_comb begin
    err = (state_q == ERR);
  end

  // Last result, change pulse and lock; all frozen outside accepted legal samples.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      last_res <= RES_NONE;
      chg      <= 1'b0;
      lock     <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (take) begin
        last_res <= dec.code;
        chg      <= (last_res != RES_NONE) && (dec.code != last_res);
        if (dec.code == RES_EQ) begin
          if (eq_hit) begin
            lock <= 1'b1;
          end
        end else begin
          lock <= 1'b0;
        end
      end
    end
  end

`ifdef CMP_HIST_EN
  logic [7:0] hist_q;

  // Shift in each accepted code, newest in the low bits.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist_q <= 8'h00;
    end else if (take) begin
      hist_q <= {hist_q[5:0], dec.code};
    end
  end

  assign hist = hist_q;
`else
  assign hist = 8'h00;
`endif

endmodule
